skolem_cex_scanner: RTL and testbench

- Sequential initiator/checker for combinational Skolem-function netlists such as SKOLEMFORMULA (universal inputs X in, existential outputs Y out).
- Walks all 2^NX assignments of X in ascending order and hands each one to the candidate over a valid/ready handshake.
- Collects the candidate's Y response and presents the (X, Y) pair to an external specification evaluator.
- Reports pass/fail, the first counterexample and the total failure count; sits in the Skolem-function regression harness.

---
 rtl/skolem_cex_scanner.sv | 179 +++++++++++++++++
 tb/tb_skolem_cex_scanner.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/skolem_cex_scanner.sv
// skolem_cex_scanner
// Walks every assignment of the universal inputs X (0 .. 2^NX-1, ascending),
// offers each one to a candidate Skolem netlist over a valid/ready handshake,
// captures the candidate's existential response Y and presents the (X, Y)
// pair to an external specification evaluator. Tracks the number of failing
// vectors and the first counterexample, and can stop at the first failure.
//
// Ports
//   clk, rst          rising-edge clock, asynchronous active-high reset
//   start             one-cycle scan request, honoured only while idle
//   stop_on_fail      latched at start: end the scan at the first failure
//   x_valid/x_ready   X handshake towards the candidate, x_out = current X
//   y_valid/y_in      candidate response (only accepted while waiting for Y)
//   phi_x/phi_y       (X, Y) pair shown to the evaluator
//   phi_ok            evaluator verdict, sampled in the check cycle
//   busy, done        scan in progress / one-cycle end-of-scan pulse
//   pass, fail_count  result of the last completed (or current) scan
//   cex_x, cex_y      first failing vector of the scan
module skolem_cex_scanner #(
    parameter int NX = 4,
    parameter int NY = 9
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          stop_on_fail,
    output logic          x_valid,
    input  logic          x_ready,
    output logic [NX-1:0] x_out,
    input  logic          y_valid,
    input  logic [NY-1:0] y_in,
    output logic [NX-1:0] phi_x,
    output logic [NY-1:0] phi_y,
    input  logic          phi_ok,
    output logic          busy,
    output logic          done,
    output logic          pass,
    output logic [NX:0]   fail_count,
    output logic [NX-1:0] cex_x,
    output logic [NY-1:0] cex_y
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ISSUE  = 3'd1,
        ST_WAIT_Y = 3'd2,
        ST_CHECK  = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    localparam logic [NX-1:0] X_LAST = {NX{1'b1}};

    state_t        state_q, state_d;
    logic [NX-1:0] x_q, x_d;
    logic [NY-1:0] y_q, y_d;
    logic [NX:0]   fail_cnt_q, fail_cnt_d;
    logic [NX-1:0] cex_x_q, cex_x_d;
    logic [NY-1:0] cex_y_q, cex_y_d;
    logic          pass_q, pass_d;
    logic          stop_q, stop_d;
    logic          x_valid_q, busy_q, done_q;
    logic          vec_fail_s;

    // Next-state and datapath updates for the scan sequencer.
    always_comb begin
        state_d    = state_q;
        x_d        = x_q;
        y_d        = y_q;
        fail_cnt_d = fail_cnt_q;
        cex_x_d    = cex_x_q;
        cex_y_d    = cex_y_q;
        pass_d     = pass_q;
        stop_d     = stop_q;
        vec_fail_s = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    fail_cnt_d = {(NX+1){1'b0}};
                    cex_x_d    = {NX{1'b0}};
                    cex_y_d    = {NY{1'b0}};
                    pass_d     = 1'b0;
                    stop_d     = stop_on_fail;
                    x_d        = {NX{1'b0}};
                    state_d    = ST_ISSUE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                // x_q is untouched here, so X stays stable under backpressure.
                if (x_ready) begin
                    state_d = ST_WAIT_Y;
                end else begin
                    state_d = ST_ISSUE;
                end
            end
            ST_WAIT_Y: begin
                if (y_valid) begin
                    y_d     = y_in;
                    state_d = ST_CHECK;
                end else begin
                    state_d = ST_WAIT_Y;
                end
            end
            ST_CHECK: begin
                vec_fail_s = ~phi_ok;
                if (vec_fail_s) begin
                    if (fail_cnt_q == {(NX+1){1'b0}}) begin
                        cex_x_d = x_q;
                        cex_y_d = y_q;
                    end else begin
                        cex_x_d = cex_x_q;
                    end
                    // At most 2^NX failures, which always fits in NX+1 bits.
                    fail_cnt_d = fail_cnt_q + {{NX{1'b0}}, 1'b1};
                end else begin
                    fail_cnt_d = fail_cnt_q;
                end
                if ((vec_fail_s && stop_q) || (x_q == X_LAST)) begin
                    // Verdict is settled on entry to DONE so it is valid with the pulse.
                    pass_d  = (fail_cnt_d == {(NX+1){1'b0}});
                    state_d = ST_DONE;
                end else begin
                    x_d     = x_q + {{(NX-1){1'b0}}, 1'b1};
                    state_d = ST_ISSUE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, datapath and registered handshake/status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            x_q        <= {NX{1'b0}};
            y_q        <= {NY{1'b0}};
            fail_cnt_q <= {(NX+1){1'b0}};
            cex_x_q    <= {NX{1'b0}};
            cex_y_q    <= {NY{1'b0}};
            pass_q     <= 1'b0;
            stop_q     <= 1'b0;
            x_valid_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            x_q        <= x_d;
            y_q        <= y_d;
            fail_cnt_q <= fail_cnt_d;
            cex_x_q    <= cex_x_d;
            cex_y_q    <= cex_y_d;
            pass_q     <= pass_d;
            stop_q     <= stop_d;
            x_valid_q  <= (state_d == ST_ISSUE);
            busy_q     <= (state_d == ST_ISSUE) || (state_d == ST_WAIT_Y) ||
                          (state_d == ST_CHECK);
            done_q     <= (state_d == ST_DONE);
        end
    end

    assign x_valid    = x_valid_q;
    assign x_out      = x_q;
    assign phi_x      = x_q;
    assign phi_y      = y_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign pass       = pass_q;
    assign fail_count = fail_cnt_q;
    assign cex_x      = cex_x_q;
    assign cex_y      = cex_y_q;

endmodule

// File: tb/tb_skolem_cex_scanner.sv
// Randomized self-checking bench for skolem_cex_scanner. A responder model
// plays the candidate netlist (golden function optionally corrupted per X),
// an evaluator flags wrong Y values plus a forced-failure mask, and a
// reference loop over all X predicts count, counterexample and stop point.
module tb_skolem_cex_scanner;

    localparam int NX = 4;
    localparam int NY = 9;
    localparam int NV = 1 << NX;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          stop_on_fail;
    logic          x_valid;
    logic          x_ready;
    logic [NX-1:0] x_out;
    logic          y_valid;
    logic [NY-1:0] y_in;
    logic [NX-1:0] phi_x;
    logic [NY-1:0] phi_y;
    logic          phi_ok;
    logic          busy;
    logic          done;
    logic          pass;
    logic [NX:0]   fail_count;
    logic [NX-1:0] cex_x;
    logic [NY-1:0] cex_y;

    skolem_cex_scanner #(.NX(NX), .NY(NY)) dut (
        .clk(clk), .rst(rst), .start(start), .stop_on_fail(stop_on_fail),
        .x_valid(x_valid), .x_ready(x_ready), .x_out(x_out),
        .y_valid(y_valid), .y_in(y_in), .phi_x(phi_x), .phi_y(phi_y),
        .phi_ok(phi_ok), .busy(busy), .done(done), .pass(pass),
        .fail_count(fail_count), .cex_x(cex_x), .cex_y(cex_y)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Scan configuration shared by the responder and the evaluator.
    logic [NV-1:0] fail_mask = '0;
    logic [NY-1:0] corrupt [NV];
    int  stall_min = 0, stall_max = 0, ydly_min = 0, ydly_max = 0;
    logic spur = 1'b0;
    logic [NX-1:0] issued [$];

    function automatic logic [NY-1:0] golden(input logic [NX-1:0] x);
        int v;
        v = int'(x) * int'(x) * 23 + int'(x) * 5 + 7;
        return NY'(v % 512);
    endfunction

    function automatic logic [NY-1:0] resp(input logic [NX-1:0] x);
        return golden(x) ^ corrupt[x];
    endfunction

    assign phi_ok = (phi_y == golden(phi_x)) && !fail_mask[phi_x];

    int done_cnt = 0;
    always @(posedge clk) if (done) done_cnt <= done_cnt + 1;

    // Candidate responder: optional accept stall, response delay and spurious y_valid.
    initial begin : responder
        logic          pend, seen;
        logic [NX-1:0] acc_x, seen_x;
        int            stall_left, dly_left;
        pend = 1'b0; seen = 1'b0; acc_x = '0; seen_x = '0;
        stall_left = 0; dly_left = 0;
        x_ready = 1'b0; y_valid = 1'b0; y_in = '0;
        forever begin
            @(negedge clk);
            x_ready = 1'b0;
            y_valid = 1'b0;
            if (rst) begin
                pend = 1'b0;
                seen = 1'b0;
            end else if (pend) begin
                if (dly_left == 0) begin
                    y_valid = 1'b1;
                    y_in    = resp(acc_x);
                    pend    = 1'b0;
                end else begin
                    dly_left--;
                end
            end else if (x_valid) begin
                if (!seen) begin
                    seen       = 1'b1;
                    seen_x     = x_out;
                    stall_left = $urandom_range(stall_max, stall_min);
                end else begin
                    chk("x_stable", 32'(x_out), 32'(seen_x));
                end
                if (stall_left == 0) begin
                    x_ready  = 1'b1;
                    acc_x    = x_out;
                    issued.push_back(x_out);
                    pend     = 1'b1;
                    dly_left = $urandom_range(ydly_max, ydly_min);
                    seen     = 1'b0;
                end else begin
                    stall_left--;
                    if (spur && ($urandom_range(1, 0) == 1)) begin
                        y_valid = 1'b1;
                        y_in    = NY'($urandom);
                    end
                end
            end
        end
    end

    task automatic set_cfg(input int smin, input int smax, input int dmin, input int dmax,
                           input logic sp);
        stall_min = smin; stall_max = smax; ydly_min = dmin; ydly_max = dmax; spur = sp;
    endtask

    task automatic clear_faults();
        fail_mask = '0;
        for (int i = 0; i < NV; i++) corrupt[i] = '0;
    endtask

    // One complete scan against the reference model.
    task automatic run_scan(input string name, input logic stop, input logic poke,
                            input logic check_lat);
        int visited, fc, cyc, done_before;
        logic [NX-1:0] cx, last_x;
        logic [NY-1:0] cy;
        logic got_done;
        visited = 0; fc = 0; cx = '0; cy = '0; last_x = '0;
        for (int x = 0; x < NV; x++) begin
            logic [NY-1:0] y;
            y = resp(NX'(x));
            visited++;
            last_x = NX'(x);
            if ((y != golden(NX'(x))) || fail_mask[x]) begin
                if (fc == 0) begin
                    cx = NX'(x);
                    cy = y;
                end
                fc++;
                if (stop) break;
            end
        end

        issued.delete();
        done_before = done_cnt;
        @(negedge clk);
        stop_on_fail = stop;
        start = 1'b1;
        cyc = 0;
        got_done = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk);
            cyc++;
            #1;
            start = 1'b0;
            if (done) begin
                got_done = 1'b1;
                break;
            end
            if (poke) start = ($urandom_range(1, 0) == 1);
        end
        if (!got_done) begin
            chk({name, "_done_timeout"}, 32'd0, 32'd1);
            start = 1'b0;
            return;
        end
        if (poke) start = 1'b1;  // request during the DONE cycle must be ignored
        if (check_lat) chk({name, "_latency"}, 32'(cyc), 32'(3 * visited + 1));
        chk({name, "_pass"}, 32'(pass), 32'(fc == 0));
        chk({name, "_fail_count"}, 32'(fail_count), 32'(fc));
        chk({name, "_cex_x"}, 32'(cex_x), 32'(cx));
        chk({name, "_cex_y"}, 32'(cex_y), 32'(cy));
        chk({name, "_x_hold"}, 32'(x_out), 32'(last_x));
        @(posedge clk);
        #1;
        start = 1'b0;
        chk({name, "_done_pulse_len"}, 32'(done), 32'd0);
        chk({name, "_done_count"}, 32'(done_cnt - done_before), 32'd1);
        chk({name, "_n_issued"}, 32'(issued.size()), 32'(visited));
        for (int i = 0; i < issued.size() && i < visited; i++)
            chk({name, "_issue_order"}, 32'(issued[i]), 32'(i));
        if (poke) begin
            repeat (4) begin
                @(posedge clk);
                #1;
                chk({name, "_no_restart"}, 32'(busy | done), 32'd0);
            end
            chk({name, "_held_fail_count"}, 32'(fail_count), 32'(fc));
        end
    endtask

    task automatic check_all_zero(input string name);
        chk({name, "_x_valid"}, 32'(x_valid), 32'd0);
        chk({name, "_busy"}, 32'(busy), 32'd0);
        chk({name, "_done"}, 32'(done), 32'd0);
        chk({name, "_pass"}, 32'(pass), 32'd0);
        chk({name, "_fail_count"}, 32'(fail_count), 32'd0);
        chk({name, "_cex"}, {19'd0, cex_x, cex_y}, 32'd0);
        chk({name, "_x_out"}, 32'(x_out), 32'd0);
        chk({name, "_phi"}, {19'd0, phi_x, phi_y}, 32'd0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; stop_on_fail = 1'b0;
        clear_faults();
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;

        // 1: golden candidate, zero-wait responder.
        set_cfg(0, 0, 0, 0, 1'b0);
        run_scan("golden", 1'b0, 1'b0, 1'b1);

        // 2/3: forced failures at X=5 and X=12, without and with stop.
        fail_mask[5] = 1'b1;
        fail_mask[12] = 1'b1;
        run_scan("fail_nostop", 1'b0, 1'b0, 1'b1);
        run_scan("fail_stop", 1'b1, 1'b0, 1'b1);
        clear_faults();

        // 4: backpressure, delayed responses, spurious y_valid while stalled.
        set_cfg(3, 3, 2, 2, 1'b1);
        run_scan("backpressure", 1'b0, 1'b0, 1'b0);

        // 5: asynchronous reset while waiting for Y of X=7, then a clean rescan.
        set_cfg(0, 0, 2, 2, 1'b0);
        fail_mask[2] = 1'b1;
        @(negedge clk);
        stop_on_fail = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        begin
            logic hit;
            hit = 1'b0;
            for (int i = 0; i < 500; i++) begin
                @(negedge clk);
                if (x_out == NX'(7) && !x_valid && busy) begin
                    hit = 1'b1;
                    break;
                end
            end
            chk("reach_x7_wait_y", 32'(hit), 32'd1);
        end
        #2 rst = 1'b1;
        #1 check_all_zero("midscan_reset");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        clear_faults();
        set_cfg(0, 0, 0, 0, 1'b0);
        run_scan("after_reset", 1'b0, 1'b0, 1'b1);

        // 6: start requests while busy and during DONE.
        fail_mask[9] = 1'b1;
        run_scan("start_poke", 1'b0, 1'b1, 1'b1);
        clear_faults();

        // Randomized scans: faults, corruption, stop mode and timing all random.
        for (int r = 0; r < 8; r++) begin
            for (int i = 0; i < NV; i++) begin
                fail_mask[i] = ($urandom_range(5, 0) == 0);
                corrupt[i]   = ($urandom_range(5, 0) == 0) ? NY'($urandom_range(511, 1)) : '0;
            end
            if (r[0]) set_cfg(0, 0, 0, 0, 1'b0);
            else      set_cfg(0, $urandom_range(3, 0), 0, $urandom_range(3, 0), 1'b1);
            run_scan("random", 1'($urandom_range(1, 0)), 1'b0, r[0]);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
